// File: rtl/count_capture_fifo.sv
// Captures {wrap epoch, count} snapshots of a free-running counter into a small FIFO
// drained over valid/ready. Build option CNT_CAP_DELTA_EN stores count deltas instead.
module count_capture_fifo #(
    parameter int CW    = 16,
    parameter int EW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [CW-1:0]              count,
    input  logic                       capture,
    input  logic                       clear_ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CW-1:0]              out_count,
    output logic [EW-1:0]              out_epoch,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [EW-1:0] epoch;
        logic [CW-1:0] count;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level_q;
    logic [CW-1:0]   prev_count;
    logic            prev_valid;
    logic [EW-1:0]   epoch_reg;
    logic            overflow_q;

    logic            wrap, pop, push, drop;
    logic [EW-1:0]   epoch_now;
    entry_t          push_entry;

`ifdef CNT_CAP_DELTA_EN
    // Reference starts at 0, so the first accepted capture stores its raw count.
    logic [CW-1:0]   last_capture;
`endif

    always_comb begin
        wrap       = prev_valid && (count < prev_count);
        epoch_now  = epoch_reg + EW'(wrap);
        pop        = (level_q != '0) && out_ready;
        push       = capture && ((level_q < LW'(DEPTH)) || pop);
        drop       = capture && !push;
        push_entry.epoch = epoch_now;
`ifdef CNT_CAP_DELTA_EN
        push_entry.count = count - last_capture;
`else
        push_entry.count = count;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            prev_count <= '0;
            prev_valid <= 1'b0;
            epoch_reg  <= '0;
            overflow_q <= 1'b0;
`ifdef CNT_CAP_DELTA_EN
            last_capture <= '0;
`endif
        end else begin
            prev_count <= count;
            prev_valid <= 1'b1;
            epoch_reg  <= epoch_now;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
`ifdef CNT_CAP_DELTA_EN
                last_capture <= count;
`endif
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            // A drop in the same cycle as clear_ovf keeps the flag set.
            if (drop)           overflow_q <= 1'b1;
            else if (clear_ovf) overflow_q <= 1'b0;
        end
    end

    // NOTE: storage is left unreset; outputs are gated by occupancy, so stale contents are never visible.
    always_ff @(posedge clock) begin
        if (!reset && push) mem[wr_ptr] <= push_entry;
    end

    assign out_valid = (level_q != '0);
    assign out_count = out_valid ? mem[rd_ptr].count : '0;
    assign out_epoch = out_valid ? mem[rd_ptr].epoch : '0;
    assign overflow  = overflow_q;
    assign level     = level_q;
endmodule

// File: doc/count_capture_fifo.md
Name: count_capture_fifo

Overview:
- Downstream consumer of the 16-bit free-running event counter.
- Each cycle: watches the counter's `count` output, detects wrap-around and keeps a wrap epoch.
- On a `capture` strobe: snapshots {epoch, count} into a small FIFO.
- Snapshots drain to the readout logic over a valid/ready handshake; a sticky overflow flag marks any dropped capture.

Parameters:
- CW, 16, width of `count` input and `out_count`.
- EW, 8, width of wrap-epoch counter and `out_epoch`.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- clock  in  1  rising-edge clock, same domain as the counter.
- reset  in  1  synchronous, active-high reset.
- count  in  CW  counter value from the upstream counter.
- capture  in  1  snapshot request, single-cycle strobe.
- clear_ovf  in  1  clears the `overflow` flag.
- out_valid  out  1  FIFO head holds a snapshot.
- out_ready  in  1  consumer accepts the head this cycle.
- out_count  out  CW  snapshot count (or delta, see Optional Feature).
- out_epoch  out  EW  snapshot epoch.
- overflow  out  1  sticky: a capture was dropped.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (synchronous, highest priority):
  - Flushes the FIFO; `level` = 0, `out_valid` = 0.
  - `out_count` = 0, `out_epoch` = 0, `overflow` = 0.
  - Epoch counter = 0; prev_count is marked invalid.
  - Reset mid-operation discards all queued entries and ignores `capture` in that cycle.
- Wrap detection:
  - prev_count is registered every cycle.
  - wrap = prev_valid && (count < prev_count).
  - prev_valid is 0 for the first cycle after reset, so no wrap is reported then.
- Epoch:
  - Increments by 1 on each wrap, modulo 2^EW (255 -> 0 silently).
  - epoch_now = epoch_reg + wrap.
  - A capture in the same cycle as a wrap records the new epoch.
- Capture:
  - `capture` in cycle t pushes {epoch_now, count sampled in cycle t}.
  - If the FIFO was empty, the entry appears at the outputs in cycle t+1 with `out_valid` = 1.
- Pop:
  - Occurs when `out_valid` && `out_ready`.
  - The next entry, if any, is presented in the following cycle.
- Stability:
  - While `out_valid` && !`out_ready`, `out_count` and `out_epoch` hold stable.
  - When the FIFO is empty, `out_count` and `out_epoch` are driven to 0.
- Full FIFO:
  - A push is accepted if `level` < DEPTH, or if a pop happens in the same cycle; in that case `level` is unchanged.
  - Otherwise the capture is dropped and `overflow` is set.
- Empty FIFO: no pop occurs; `out_ready` is ignored.
- `level`: updated each cycle as +1 on push only, -1 on pop only, unchanged on both or neither.
- `overflow` clearing:
  - `clear_ovf` clears it on the next edge.
  - If a drop and `clear_ovf` occur in the same cycle, set wins and `overflow` stays 1.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Registers are implemented as flops only; no combinational path from `capture` to `out_*`.

Optional Feature:
- Macro: CNT_CAP_DELTA_EN.
- Defined:
  - `out_count` = captured count minus the previous accepted capture's count, modulo 2^CW, computed at push time.
  - The first accepted capture after reset stores the raw count.
  - Dropped captures do not update the previous-capture reference.
  - `out_epoch` is unchanged and remains the absolute epoch.
- Not defined: `out_count` is the raw sampled count. No extra registers are generated.

Test Plan:
- Basic capture:
  - Stimulus: release reset with count = 5, 6, 7…; pulse `capture` when count = 7; hold `out_ready` = 0.
  - Required: next cycle `out_valid` = 1, `out_count` = 7, `out_epoch` = 0, `level` = 1; values hold stable across 3 cycles; `out_ready` = 1 for one cycle -> `out_valid` = 0, `level` = 0.
- Wrap with simultaneous capture:
  - Stimulus: count 65534, 65535, 0; capture on the cycle count = 0.
  - Required: `out_count` = 0, `out_epoch` = 1. After 256 wraps the epoch reads 0.
- Overflow:
  - Stimulus: DEPTH = 4, `out_ready` = 0, 5 captures at count 10..14.
  - Required: `level` = 4, `overflow` = 1, entries read 10, 11, 12, 13 (14 dropped).
  - Then `clear_ovf` -> `overflow` = 0; `clear_ovf` together with a dropped capture -> `overflow` stays 1.
- Full with concurrent push/pop:
  - Stimulus: `level` = 4, `out_ready` = 1 and `capture` in the same cycle.
  - Required: `level` stays 4, `overflow` stays 0, new sample is last in order.
- Reset mid-operation:
  - Stimulus: `level` = 3, epoch = 2, `overflow` = 1; assert `reset` for 1 cycle together with `capture`.
  - Required: all outputs 0, epoch 0, no wrap reported on the first post-reset cycle even if count < the pre-reset value.
- Delta mode (CNT_CAP_DELTA_EN):
  - Stimulus: captures at count 100, 250, then 65530 -> wrap -> 20.
  - Required: outputs 100, 150, 65280, 26; epochs 0, 0, 0, 1.
